// File: rtl/pio_ext_pkg.sv
// Shared constants for the pio_ext parallel I/O block: register map and capture-edge encodings.
package pio_ext_pkg;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   function automatic logic edge_fire(input logic cur, input logic prev,
                                      input int unsigned edge_type);
      logic hit;
      case (edge_type)
         EDGE_RISE: hit = cur & ~prev;
         EDGE_FALL: hit = ~cur & prev;
         default:   hit = cur ^ prev;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/pio_ext_filter.sv
// Per-pin two-flop synchroniser with optional debounce (compiled in by PIO_EXT_DEBOUNCE_EN).
module pio_ext_filter #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
      end
   end

`ifdef PIO_EXT_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;

   // Counter runs only while sync differs from the accepted level; a return resets it.
   always_comb begin
      cnt_d = '0;
      out_d = out_q;
      if (sync_q != out_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            out_d = sync_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         out_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   assign dout = out_q;
`else
   assign dout = sync_q;
`endif

endmodule

// File: rtl/pio_ext.sv
// Avalon-MM parallel I/O port with edge capture and level irq.
// Debounce is compiled in with PIO_EXT_DEBOUNCE_EN.
module pio_ext
   import pio_ext_pkg::*;
#(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter logic [31:0] RESET_OUT       = 32'd0
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic [2:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             irq,
   input  logic [WIDTH-1:0] pio_in,
   output logic [WIDTH-1:0] pio_out,
   output logic [WIDTH-1:0] pio_oe
);

   logic [WIDTH-1:0] filtered, filt_q;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [WIDTH-1:0] wd, hit;
   logic [31:0]      rdata_q, rdata_d, rd_val;
   logic             irq_q, irq_d;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      pio_ext_filter #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
         .clk  (clk_clk),
         .rst_n(reset_reset_n),
         .din  (pio_in[g]),
         .dout (filtered[g])
      );
   end

   assign wd = WIDTH'(avs_writedata);

   always_comb begin
      out_d  = out_q;
      dir_d  = dir_q;
      mask_d = mask_q;
      cap_d  = cap_q;
      if (avs_write) begin
         case (avs_address)
            ADDR_DATA:    out_d  = wd;
            ADDR_DIR:     dir_d  = wd;
            ADDR_IRQMASK: mask_d = wd;
            ADDR_EDGECAP: cap_d  = cap_q & ~wd;
            ADDR_OUTSET:  out_d  = out_q | wd;
            ADDR_OUTCLR:  out_d  = out_q & ~wd;
            default:      ;
         endcase
      end
      for (int i = 0; i < WIDTH; i++) begin
         hit[i] = edge_fire(filtered[i], filt_q[i], EDGE_TYPE);
      end
      // Capture is applied after the clear so a same-cycle edge survives.
      cap_d = cap_d | hit;
      irq_d = |(cap_q & mask_q);

      rd_val = '0;
      case (avs_address)
         ADDR_DATA:    rd_val[WIDTH-1:0] = filtered;
         ADDR_DIR:     rd_val[WIDTH-1:0] = dir_q;
         ADDR_IRQMASK: rd_val[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: rd_val[WIDTH-1:0] = cap_q;
         default:      ;
      endcase
      rdata_d = avs_read ? rd_val : rdata_q;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         out_q   <= RESET_OUT[WIDTH-1:0];
         dir_q   <= '0;
         mask_q  <= '0;
         cap_q   <= '0;
         filt_q  <= '0;
         irq_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         out_q   <= out_d;
         dir_q   <= dir_d;
         mask_q  <= mask_d;
         cap_q   <= cap_d;
         filt_q  <= filtered;
         irq_q   <= irq_d;
         rdata_q <= rdata_d;
      end
   end

   assign pio_out      = out_q;
   assign pio_oe       = dir_q;
   assign irq          = irq_q;
   assign avs_readdata = rdata_q;

endmodule

// File: doc/pio_ext.md
PIO_EXT -- requirements
Module: pio_ext

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pin count, legal range 1..32.
REQ-002 SHALL have parameter EDGE_TYPE, default 0: capture edge, 0 rising, 1 falling, 2 any.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable-cycle count, legal range 2..2^20, used only with debounce compiled in.
REQ-004 SHALL have parameter RESET_OUT, default 0: reset value of the output data register.
REQ-005 SHALL have port clk_clk  in  1: single clock for all logic.
REQ-006 SHALL have port reset_reset_n  in  1: reset, asynchronous and active-low.
REQ-007 SHALL have port avs_address  in  3: register index.
REQ-008 SHALL have ports avs_read, avs_write  in  1 each: Avalon-MM strobes.
REQ-009 SHALL have ports avs_writedata  in  32 and avs_readdata  out  32.
REQ-010 SHALL have port irq  out  1: level interrupt, active-high.
REQ-011 SHALL have ports pio_in  in  WIDTH, pio_out  out  WIDTH and pio_oe  out  WIDTH (1 = bit driven).

Function
REQ-012 SHALL decode registers at these addresses:
- 0 DATA: read returns filtered input; write loads out_reg.
- 1 DIR: read/write, 1 = output.
- 2 IRQMASK: read/write.
- 3 EDGECAP: read; write-1-to-clear.
- 4 OUTSET: write, out_reg |= wd.
- 5 OUTCLR: write, out_reg &= ~wd.
- 6, 7: read 0, writes ignored.
REQ-013 SHALL use fixed read latency 1: avs_readdata is valid in the cycle after avs_read is sampled, and holds otherwise.
REQ-014 SHALL ignore writedata bits at and above WIDTH, and SHALL return 0 in readdata bits at and above WIDTH.
REQ-015 SHALL drive pio_out = out_reg and pio_oe = DIR register, both directly from flops.
REQ-016 SHALL synchronise pio_in through 2 flops per bit; the second flop gives sync_in.
REQ-017 SHALL register filtered input into filt_q, and SHALL set a EDGECAP bit on the chosen edge of filtered versus filt_q.
REQ-018 SHALL, without debounce, set EDGECAP at the 3rd rising clock after a pio_in change.
REQ-019 SHALL, when a capture and a W1C clear hit the same bit in the same cycle, leave that bit set (capture wins).
REQ-020 SHALL make irq a registered |(EDGECAP & IRQMASK), asserted 1 cycle after the contributing bit sets or the mask changes.
REQ-021 SHALL capture edges on output-direction bits too, since it reads back the pin.
REQ-022 SHALL accept avs_read and avs_write in the same cycle: the write takes effect and the read returns pre-write contents.

Reset
REQ-023 SHALL set on reset: out_reg = RESET_OUT, DIR = 0, IRQMASK = 0, EDGECAP = 0, irq = 0, avs_readdata = 0, sync/filt/debounce state = 0.
REQ-024 SHALL, on reset mid-debounce or mid-read, abandon the operation with no capture and no readdata-valid cycle after release.

Configuration
REQ-025 SHALL, with PIO_EXT_DEBOUNCE_EN defined, give each bit a counter: it restarts on any sync_in change and updates filtered only after sync_in holds for DEBOUNCE_CYCLES consecutive cycles.
REQ-026 SHALL, without PIO_EXT_DEBOUNCE_EN, make filtered = sync_in, with no counters synthesised and DEBOUNCE_CYCLES ignored.

Structure
REQ-027 SHALL put register address constants (ADDR_DATA..ADDR_OUTCLR) and edge-type constants in shared package pio_ext_pkg.
REQ-028 SHALL implement per-bit sync and debounce in sub-module pio_ext_filter, instantiated WIDTH times through a generate loop.

Verification
REQ-029 SHALL cover reset: RESET_OUT=8'hA5, release reset -> pio_out=A5, pio_oe=00, irq=0, and reads of addr 0..5 return the expected values.
REQ-030 SHALL cover capture and irq: EDGE_TYPE=0, mask=01, pio_in[0] 0->1 -> EDGECAP=01 at the 3rd clock, irq=1 at the 4th; write 01 to addr 3 -> irq=0 one cycle after EDGECAP clears.
REQ-031 SHALL cover the clear collision: W1C to bit 2 in the same cycle a bit-2 edge is captured -> EDGECAP[2] stays 1.
REQ-032 SHALL cover set/clear writes: out_reg=F0, OUTSET 0F -> FF, OUTCLR 81 -> 7E, and writedata 32'hFFFF_FF00 to addr 0 -> pio_out=00.
REQ-033 SHALL cover debounce with PIO_EXT_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: 3-cycle glitch -> no capture; 6-cycle pulse -> exactly one capture.
REQ-034 SHALL cover unused addresses and read latency: read addr 6 -> 0 one cycle later; simultaneous read+write to addr 2 returns the old mask.
